// File: rtl/multiport_register_file_pkg.sv
// Shared constants and helpers for the multiport register file.
// Register NUM_REGS-1 doubles as the program counter.
package multiport_register_file_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NUM_REGS = 16;
    localparam int DEF_NUM_RD   = 3;
    localparam int DEF_BYPASS   = 1;
    localparam int DEF_PC_INC   = 4;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_PC_IDX   = DEF_NUM_REGS - 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1)
            r++;
        return r;
    endfunction

    function automatic int pc_index(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// Per-register pending-load flags; mark wins over a same-edge clear.
// The PC register can never be pending.
module rf_scoreboard
    import multiport_register_file_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = clog2(NUM_REGS),
    parameter int PC_IDX   = pc_index(NUM_REGS)
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mark_en,
    input  logic [ADDR_W-1:0]   mark_addr,
    input  logic                clr_en,
    input  logic [ADDR_W-1:0]   clr_addr,
    output logic [NUM_REGS-1:0] pending
);

    logic [NUM_REGS-1:0] pend_nxt;

    always_comb begin
        pend_nxt = pending;
        if (clr_en)
            pend_nxt[clr_addr] = 1'b0;
        if (mark_en)
            pend_nxt[mark_addr] = 1'b1;
        pend_nxt[PC_IDX] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= pend_nxt;
    end

endmodule

// File: rtl/multiport_register_file.sv
// Two-write, NUM_RD-read register file with built-in PC register,
// optional write-to-read forwarding and load-pending tracking.
module multiport_register_file
    import multiport_register_file_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                NUM_REGS = DEF_NUM_REGS,
    parameter int                NUM_RD   = DEF_NUM_RD,
    parameter int                BYPASS   = DEF_BYPASS,
    parameter int                PC_INC   = DEF_PC_INC,
    parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEF_RESET_PC),
    localparam int               ADDR_W   = clog2(NUM_REGS)
)(
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [DATA_W-1:0]          PW0,
    input  logic [ADDR_W-1:0]          RW0,
    input  logic                       E0,
    input  logic [DATA_W-1:0]          PW1,
    input  logic [ADDR_W-1:0]          RW1,
    input  logic                       E1,
    input  logic                       PC_EN,
    input  logic                       MARK_EN,
    input  logic [ADDR_W-1:0]          MARK_ADDR,
    input  logic [NUM_RD*ADDR_W-1:0]   RA,
    output logic [NUM_RD*DATA_W-1:0]   PA,
    output logic [NUM_RD-1:0]          BUSY,
    output logic [DATA_W-1:0]          PC
);

    localparam int PC_IDX = pc_index(NUM_REGS);

    // Gating with RESET keeps forwarded values at reset state during reset.
    logic e0_g;
    logic e1_g;
    logic pc_en_g;
    logic mark_g;

    assign e0_g    = E0 & RESET;
    assign e1_g    = E1 & RESET;
    assign pc_en_g = PC_EN & RESET;
    assign mark_g  = MARK_EN & RESET;

    logic [DATA_W-1:0]   cur [NUM_REGS];
    logic [DATA_W-1:0]   nxt [NUM_REGS];
    logic [NUM_REGS-1:0] pending;

    generate
        for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
            localparam logic [ADDR_W-1:0] ADDR    = ADDR_W'(r);
            localparam logic [DATA_W-1:0] RST_VAL =
                (r == PC_IDX) ? RESET_PC : '0;

            logic              hit0;
            logic              hit1;
            logic              inc;
            logic [DATA_W-1:0] q;

            assign hit0 = e0_g && (RW0 == ADDR);
            assign hit1 = e1_g && (RW1 == ADDR);
            assign inc  = (r == PC_IDX) && pc_en_g;

            assign nxt[r] = hit0 ? PW0 :
                            hit1 ? PW1 :
                            inc  ? q + DATA_W'(PC_INC) : q;

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET)
                    q <= RST_VAL;
                else
                    q <= nxt[r];
            end

            assign cur[r] = q;
        end

        for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] a;

            assign a = RA[k*ADDR_W +: ADDR_W];

            if (BYPASS != 0) begin : g_byp
                logic clr_hit;

                assign clr_hit = e1_g && (RW1 == a) &&
                                 !(mark_g && (MARK_ADDR == a));
                assign PA[k*DATA_W +: DATA_W] = nxt[a];
                assign BUSY[k] = pending[a] & ~clr_hit;
            end else begin : g_nobyp
                assign PA[k*DATA_W +: DATA_W] = cur[a];
                assign BUSY[k] = pending[a];
            end
        end
    endgenerate

    assign PC = cur[PC_IDX];

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .PC_IDX   (PC_IDX)
    ) u_sb (
        .clk       (CLK),
        .rst_n     (RESET),
        .mark_en   (mark_g),
        .mark_addr (MARK_ADDR),
        .clr_en    (e1_g),
        .clr_addr  (RW1),
        .pending   (pending)
    );

endmodule

// File: tb/tb_multiport_register_file.sv
// Bench for multiport_register_file: a default bypassing instance and
// a wide, non-bypassing 16-bit instance, checked through a scoreboard queue.
module tb_multiport_register_file;

    localparam int K_PA   = 0;
    localparam int K_BUSY = 1;
    localparam int K_PC   = 2;

    logic CLK = 1'b0;
    logic RESET;

    logic [31:0] a_pw0, a_pw1, a_pc;
    logic [3:0]  a_rw0, a_rw1, a_mark_addr;
    logic        a_e0, a_e1, a_pc_en, a_mark_en;
    logic [11:0] a_ra;
    logic [95:0] a_pa;
    logic [2:0]  a_busy;

    logic [15:0] b_pw0, b_pw1, b_pc;
    logic [4:0]  b_rw0, b_rw1, b_mark_addr;
    logic        b_e0, b_e1, b_pc_en, b_mark_en;
    logic [19:0] b_ra;
    logic [63:0] b_pa;
    logic [3:0]  b_busy;

    multiport_register_file dut_a (
        .CLK(CLK), .RESET(RESET),
        .PW0(a_pw0), .RW0(a_rw0), .E0(a_e0),
        .PW1(a_pw1), .RW1(a_rw1), .E1(a_e1),
        .PC_EN(a_pc_en), .MARK_EN(a_mark_en), .MARK_ADDR(a_mark_addr),
        .RA(a_ra), .PA(a_pa), .BUSY(a_busy), .PC(a_pc)
    );

    multiport_register_file #(
        .DATA_W(16), .NUM_REGS(32), .NUM_RD(4), .BYPASS(0),
        .RESET_PC(16'h1000)
    ) dut_b (
        .CLK(CLK), .RESET(RESET),
        .PW0(b_pw0), .RW0(b_rw0), .E0(b_e0),
        .PW1(b_pw1), .RW1(b_rw1), .E1(b_e1),
        .PC_EN(b_pc_en), .MARK_EN(b_mark_en), .MARK_ADDR(b_mark_addr),
        .RA(b_ra), .PA(b_pa), .BUSY(b_busy), .PC(b_pc)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        int          dut;
        int          kind;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] m_reg  [16];
    logic        m_pend [16];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] observe(input int dut, input int kind,
                                            input int idx);
        if (dut == 0) begin
            case (kind)
                K_PA:    return a_pa[idx*32 +: 32];
                K_BUSY:  return {31'b0, a_busy[idx]};
                default: return a_pc;
            endcase
        end else begin
            case (kind)
                K_PA:    return {16'b0, b_pa[idx*16 +: 16]};
                K_BUSY:  return {31'b0, b_busy[idx]};
                default: return {16'b0, b_pc};
            endcase
        end
    endfunction

    task automatic expect_out(input string tag, input int dut, input int kind,
                              input int idx, input logic [31:0] exp);
        exp_t e;
        e.tag = tag; e.dut = dut; e.kind = kind; e.idx = idx; e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.dut, e.kind, e.idx), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        a_e0 = 0; a_e1 = 0; a_pc_en = 0; a_mark_en = 0;
        b_e0 = 0; b_e1 = 0; b_pc_en = 0; b_mark_en = 0;
    endtask

    task automatic set_ra_a(input int k, input logic [3:0] v);
        a_ra[k*4 +: 4] = v;
    endtask

    task automatic set_ra_b(input int k, input logic [4:0] v);
        b_ra[k*5 +: 5] = v;
    endtask

    function automatic logic [31:0] mnext(input int r);
        if (a_e0 && a_rw0 == 4'(r))
            return a_pw0;
        if (a_e1 && a_rw1 == 4'(r))
            return a_pw1;
        if (r == 15 && a_pc_en)
            return m_reg[15] + 32'd4;
        return m_reg[r];
    endfunction

    function automatic logic [3:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return 4'd15;
        return 4'($urandom_range(0, 7));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d done",
                 n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] nx [16];
        logic [3:0]  ad;
        logic        bz;

        RESET = 0;
        a_pw0 = 0; a_pw1 = 0; a_rw0 = 0; a_rw1 = 0; a_mark_addr = 0;
        b_pw0 = 0; b_pw1 = 0; b_rw0 = 0; b_rw1 = 0; b_mark_addr = 0;
        a_ra = 0; b_ra = 0;
        idle();

        // Reset state
        set_ra_a(1, 3); set_ra_a(2, 15);
        set_ra_b(3, 31);
        #12;
        expect_out("rst_pa0", 0, K_PA, 0, 0);
        expect_out("rst_pa1", 0, K_PA, 1, 0);
        expect_out("rst_pa_pc", 0, K_PA, 2, 0);
        for (int k = 0; k < 3; k++)
            expect_out("rst_busy", 0, K_BUSY, k, 0);
        expect_out("rst_pc", 0, K_PC, 0, 0);
        expect_out("b_rst_pa_pc", 1, K_PA, 3, 32'h1000);
        expect_out("b_rst_pcout", 1, K_PC, 0, 32'h1000);
        drain();
        @(negedge CLK);
        RESET = 1;
        tick();

        // Forwarded write then stored value
        a_e0 = 1; a_rw0 = 3; a_pw0 = 32'hDEADBEEF;
        set_ra_a(0, 3);
        expect_out("byp_r3", 0, K_PA, 0, 32'hDEADBEEF);
        expect_out("byp_r3_p1", 0, K_PA, 1, 32'hDEADBEEF);
        drain();
        tick();
        idle();
        expect_out("r3_stored", 0, K_PA, 0, 32'hDEADBEEF);
        drain();

        // Write collision: port 0 wins
        a_e0 = 1; a_rw0 = 5; a_pw0 = 32'h11;
        a_e1 = 1; a_rw1 = 5; a_pw1 = 32'h22;
        set_ra_a(0, 5);
        expect_out("coll_byp", 0, K_PA, 0, 32'h11);
        drain();
        tick();
        idle();
        expect_out("coll_r5", 0, K_PA, 0, 32'h11);
        drain();

        // PC wrap and explicit override
        a_e0 = 1; a_rw0 = 15; a_pw0 = 32'hFFFFFFFC;
        tick();
        idle();
        expect_out("pc_set", 0, K_PC, 0, 32'hFFFFFFFC);
        drain();
        a_pc_en = 1;
        set_ra_a(0, 15);
        expect_out("pc_wrap_byp", 0, K_PA, 0, 0);
        drain();
        tick();
        a_e0 = 1; a_rw0 = 15; a_pw0 = 32'h100;
        expect_out("pc_wrap", 0, K_PC, 0, 0);
        expect_out("pc_ovr_byp", 0, K_PA, 0, 32'h100);
        drain();
        tick();
        a_e0 = 0;
        expect_out("pc_ovr", 0, K_PC, 0, 32'h100);
        expect_out("pc_inc_byp", 0, K_PA, 0, 32'h104);
        drain();
        tick();
        a_pc_en = 0;
        expect_out("pc_inc", 0, K_PC, 0, 32'h104);
        drain();

        // Pending flags
        a_mark_en = 1; a_mark_addr = 7;
        set_ra_a(0, 7);
        expect_out("mark_pre", 0, K_BUSY, 0, 0);
        drain();
        tick();
        idle();
        expect_out("marked", 0, K_BUSY, 0, 1);
        drain();
        a_e1 = 1; a_rw1 = 7; a_pw1 = 32'h77;
        a_mark_en = 1; a_mark_addr = 7;
        expect_out("setclr_byp", 0, K_BUSY, 0, 1);
        drain();
        tick();
        idle();
        expect_out("setclr", 0, K_BUSY, 0, 1);
        expect_out("ld_r7", 0, K_PA, 0, 32'h77);
        drain();
        a_e1 = 1; a_rw1 = 7; a_pw1 = 32'h78;
        expect_out("clr_byp", 0, K_BUSY, 0, 0);
        drain();
        tick();
        idle();
        expect_out("clr", 0, K_BUSY, 0, 0);
        drain();
        a_mark_en = 1; a_mark_addr = 15;
        tick();
        idle();
        set_ra_a(0, 15);
        expect_out("mark_pc", 0, K_BUSY, 0, 0);
        drain();
        a_mark_en = 1; a_mark_addr = 8;
        tick();
        idle();
        a_e0 = 1; a_rw0 = 8; a_pw0 = 32'h88;
        set_ra_a(1, 8);
        expect_out("p0_noclr_byp", 0, K_BUSY, 1, 1);
        drain();
        tick();
        idle();
        expect_out("p0_noclr", 0, K_BUSY, 1, 1);
        drain();

        // Asynchronous reset between edges
        a_e0 = 1; a_rw0 = 2; a_pw0 = 32'h55;
        tick();
        idle();
        set_ra_a(0, 2);
        expect_out("r2_pre", 0, K_PA, 0, 32'h55);
        drain();
        #1;
        RESET = 0;
        a_e0 = 1; a_rw0 = 4; a_pw0 = 32'h9;
        a_mark_en = 1; a_mark_addr = 4; a_pc_en = 1;
        set_ra_a(2, 4);
        expect_out("rst_r2", 0, K_PA, 0, 0);
        expect_out("rst_pc_async", 0, K_PC, 0, 0);
        expect_out("rst_busy8", 0, K_BUSY, 1, 0);
        expect_out("rst_ign_byp", 0, K_PA, 2, 0);
        drain();
        tick();
        expect_out("rst_ign", 0, K_PA, 2, 0);
        expect_out("rst_ign_mark", 0, K_BUSY, 2, 0);
        expect_out("rst_ign_pc", 0, K_PC, 0, 0);
        drain();
        idle();
        @(negedge CLK);
        RESET = 1;
        tick();

        // Random traffic against a reference model
        for (int r = 0; r < 16; r++) begin
            m_reg[r]  = 0;
            m_pend[r] = 0;
        end
        for (int c = 0; c < 300; c++) begin
            a_e0 = 1'($urandom_range(0, 1));
            a_e1 = 1'($urandom_range(0, 1));
            a_pc_en = ($urandom_range(0, 3) == 0);
            a_mark_en = ($urandom_range(0, 2) == 0);
            a_rw0 = rand_addr(); a_rw1 = rand_addr();
            a_mark_addr = rand_addr();
            a_pw0 = $urandom; a_pw1 = $urandom;
            for (int k = 0; k < 3; k++) begin
                ad = rand_addr();
                set_ra_a(k, ad);
                bz = m_pend[ad] && !(a_e1 && a_rw1 == ad &&
                     !(a_mark_en && a_mark_addr == ad));
                expect_out("rnd_pa", 0, K_PA, k, mnext(int'(ad)));
                expect_out("rnd_busy", 0, K_BUSY, k, {31'b0, bz});
            end
            expect_out("rnd_pc", 0, K_PC, 0, m_reg[15]);
            drain();
            for (int r = 0; r < 16; r++)
                nx[r] = mnext(r);
            tick();
            for (int r = 0; r < 16; r++)
                m_reg[r] = nx[r];
            if (a_e1)
                m_pend[a_rw1] = 0;
            if (a_mark_en)
                m_pend[a_mark_addr] = 1;
            m_pend[15] = 0;
        end
        idle();

        // Wide, narrow-data, non-forwarding instance
        b_ra = 0;
        set_ra_b(3, 31);
        expect_out("b_rst_pc", 1, K_PC, 0, 32'h1000);
        expect_out("b_rst_pa3", 1, K_PA, 3, 32'h1000);
        drain();
        b_e0 = 1; b_rw0 = 3; b_pw0 = 16'hBEEF;
        set_ra_b(0, 3);
        expect_out("b_nobyp", 1, K_PA, 0, 0);
        drain();
        tick();
        idle();
        expect_out("b_r3", 1, K_PA, 0, 32'hBEEF);
        drain();
        b_e0 = 1; b_rw0 = 5; b_pw0 = 16'h11;
        b_e1 = 1; b_rw1 = 5; b_pw1 = 16'h22;
        set_ra_b(1, 5);
        tick();
        idle();
        expect_out("b_coll", 1, K_PA, 1, 32'h11);
        drain();
        b_e0 = 1; b_rw0 = 31; b_pw0 = 16'hFFFC;
        tick();
        idle();
        expect_out("b_pc_set", 1, K_PC, 0, 32'hFFFC);
        drain();
        b_pc_en = 1;
        expect_out("b_pc_nobyp", 1, K_PA, 3, 32'hFFFC);
        drain();
        tick();
        b_e0 = 1; b_rw0 = 31; b_pw0 = 16'h100;
        expect_out("b_pc_wrap", 1, K_PC, 0, 0);
        expect_out("b_ovr_nobyp", 1, K_PA, 3, 0);
        drain();
        tick();
        idle();
        expect_out("b_pc_ovr", 1, K_PC, 0, 32'h100);
        drain();
        b_mark_en = 1; b_mark_addr = 20;
        tick();
        idle();
        set_ra_b(2, 20);
        expect_out("b_marked", 1, K_BUSY, 2, 1);
        drain();
        b_e1 = 1; b_rw1 = 20; b_pw1 = 16'h20;
        b_mark_en = 1; b_mark_addr = 20;
        expect_out("b_setclr_now", 1, K_BUSY, 2, 1);
        drain();
        tick();
        idle();
        expect_out("b_setclr", 1, K_BUSY, 2, 1);
        drain();
        b_e1 = 1; b_rw1 = 20; b_pw1 = 16'h21;
        expect_out("b_clr_nobyp", 1, K_BUSY, 2, 1);
        drain();
        tick();
        idle();
        expect_out("b_clr", 1, K_BUSY, 2, 0);
        expect_out("b_ld_r20", 1, K_PA, 2, 32'h21);
        drain();
        #1;
        RESET = 0;
        expect_out("b_rst_pc2", 1, K_PC, 0, 32'h1000);
        expect_out("b_rst_r3", 1, K_PA, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 Parameter DATA_W, default 32, register width in bits.
REQ-002 Parameter NUM_REGS, default 16, register count; power of two, at least 4; ADDR_W = clog2(NUM_REGS).
REQ-003 Parameter NUM_RD, default 3, number of read ports, 1 to 4.
REQ-004 Parameter BYPASS, default 1, write-to-read forwarding enable.
REQ-005 Parameter PC_INC, default 4, program-counter increment; parameter RESET_PC, default 0, program-counter reset value.
REQ-006 The module SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-007 CLK  in  1  rising-edge clock.
REQ-008 RESET  in  1  asynchronous active-low reset.
REQ-009 PW0 / RW0 / E0  in  DATA_W / ADDR_W / 1  write port 0 (ALU result) data, address, enable.
REQ-010 PW1 / RW1 / E1  in  DATA_W / ADDR_W / 1  write port 1 (load writeback) data, address, enable.
REQ-011 PC_EN  in  1  advance program counter this cycle.
REQ-012 MARK_EN / MARK_ADDR  in  1 / ADDR_W  flag a register as pending a load.
REQ-013 RA  in  NUM_RD*ADDR_W  packed read addresses; port k uses slice k.
REQ-014 PA  out  NUM_RD*DATA_W  packed read data, slice k for port k.
REQ-015 BUSY  out  NUM_RD  pending flag of the register addressed by each read port.
REQ-016 PC  out  DATA_W  current value of register NUM_REGS-1.

Function
REQ-017 Register NUM_REGS-1 SHALL act as the program counter; all others are general purpose.
REQ-018 On each rising CLK edge, a register SHALL load PW0 when E0=1 and RW0 addresses it, else PW1 when E1=1 and RW1 addresses it; port 0 wins on address collision.
REQ-019 The PC register SHALL load PC+PC_INC (modulo 2^DATA_W) when PC_EN=1 and no write port targets it; an explicit write SHALL override the increment.
REQ-020 Reads SHALL be combinational, zero-latency; any number of ports may address the same register.
REQ-021 With BYPASS=1, a read of a register being written this cycle SHALL return the value it will hold after the edge (port 0 over port 1 over PC increment); with BYPASS=0, the stored value.
REQ-022 The pending bit of MARK_ADDR SHALL be set at the edge when MARK_EN=1.
REQ-023 The pending bit of RW1 SHALL be cleared at the edge when E1=1; port 0 writes SHALL NOT clear pending bits.
REQ-024 Simultaneous set and clear of the same pending bit SHALL leave it set.
REQ-025 BUSY[k] SHALL reflect the stored pending bit; with BYPASS=1, BUSY[k] SHALL read 0 when a port-1 clear of that register occurs this cycle and no mark of it occurs.
REQ-026 Marking the PC register SHALL be ignored; its pending bit is constant 0.
REQ-027 Address values are always in range; no out-of-range handling.

Reset
REQ-028 RESET=0 SHALL immediately force all general registers to 0, PC to RESET_PC, and all pending bits to 0, regardless of CLK.
REQ-029 Write, mark and PC_EN inputs SHALL be ignored while RESET=0; the first edge after deassertion SHALL operate normally.
REQ-030 Outputs during reset SHALL reflect reset state (PA slices 0 or RESET_PC, BUSY 0).

Structure
REQ-031 A shared package SHALL hold the clog2 function, default parameter constants, and the PC index constant NUM_REGS-1.
REQ-032 Pending-bit logic SHALL be one sub-module, rf_scoreboard (inputs mark/clear/addresses, output pending vector).
REQ-033 Storage and read muxes SHALL be generate loops over NUM_REGS and NUM_RD.

Verification
REQ-034 Reset, then E0=1 RW0=3 PW0=0xDEADBEEF; RA port0=3 same cycle -> PA0=0xDEADBEEF (bypass); next cycle stored value still 0xDEADBEEF.
REQ-035 E0=1 RW0=5 PW0=0x11, E1=1 RW1=5 PW1=0x22 same edge -> r5=0x11.
REQ-036 PC=0xFFFFFFFC, PC_EN=1 -> PC=0x00000000; PC_EN=1 with E0=1 RW0=15 PW0=0x100 -> PC=0x100.
REQ-037 MARK r7; BUSY for RA=7 is 1; E1 RW1=7 plus MARK r7 same edge -> BUSY stays 1; next E1 RW1=7 alone -> BUSY 0 (0 in that cycle with bypass).
REQ-038 Write r2=0x55, assert RESET mid-cycle between edges -> r2=0, PC=RESET_PC immediately, no edge required.
REQ-039 Rerun the above with NUM_REGS=32, NUM_RD=4, DATA_W=16, BYPASS=0 -> same-cycle reads return old value; all other results scale accordingly.
